loopback_gen: RTL and testbench

Parametrised, registered successor to the combinational loopback test design in the multi-project harness. It maps a single `in` bus to a single `out` bus in one of four runtime-selected modes: a registered XOR-chain echo, a free-running counter, a Galois LFSR pattern generator, and a MISR signature accumulator. Bring-up software uses it to check pad connectivity, clocking and the harness mux without any other project present. One output bit carries clock evidence.

---
 rtl/loopback_gen_pkg.sv | 38 +++
 rtl/loopback_gen_if.sv | 13 +
 rtl/loopback_gen_prbs.sv | 15 +
 rtl/loopback_gen.sv | 94 +++++++++
 tb/tb_loopback_gen.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/loopback_gen_pkg.sv
// Shared types and constants for the loopback_gen bring-up block:
// mode encoding, seed fills and the Galois tap table.
package loopback_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_COUNT = 2'b01,
        MODE_LFSR  = 2'b10,
        MODE_MISR  = 2'b11
    } mode_e;

    localparam logic SEED_FILL_COUNT = 1'b0;
    localparam logic SEED_FILL_PRBS  = 1'b1;

    // Right-shift Galois masks of maximal-length polynomials, widths 3..16.
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] taps;
        case (width)
            3:       taps = 16'h0006;
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0E08;
            13:      taps = 16'h1C80;
            14:      taps = 16'h3802;
            15:      taps = 16'h6000;
            16:      taps = 16'hB400;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/loopback_gen_if.sv
// Pad-side bus of loopback_gen: the harness drives 'in', the block drives 'out'.
interface loopback_gen_if #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 8
) ();

    logic [IN_W-1:0]  in;
    logic [OUT_W-1:0] out;

    modport master (output in, input out);
    modport slave  (input in, output out);

endinterface

// File: rtl/loopback_gen_prbs.sv
// One combinational Galois step of width P, shared by the LFSR and MISR modes.
module loopback_prbs
    import loopback_pkg::*;
#(
    parameter int P = 7
) (
    input  logic [P-1:0] state_i,
    output logic [P-1:0] next_o
);

    localparam logic [P-1:0] TAPS = P'(lfsr_taps(P));

    assign next_o = (state_i >> 1) ^ (state_i[0] ? TAPS : '0);

endmodule

// File: rtl/loopback_gen.sv
// Registered loopback pattern generator: PASS echo, COUNT, LFSR and MISR modes.
// out[0] is clk itself when LOOPBACK_CLK_PASS_EN is defined, otherwise a clk/2 toggle flop.
module loopback_gen
    import loopback_pkg::*;
#(
    parameter int IN_W  = 9,
    parameter int OUT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    loopback_gen_if.slave lb
);

    localparam int D = IN_W - 2;
    localparam int P = OUT_W - 1;

    if (IN_W < 4 || OUT_W < 4 || OUT_W > 17 || (OUT_W - 1) > (IN_W - 2)) begin : gBadParams
        $error("loopback_gen: illegal IN_W/OUT_W combination");
    end

    mode_e          mode_q;
    mode_e          modeIn;
    logic           modeChange;
    logic [D-1:0]   data;
    logic [D:0]     chain;
    logic [P-1:0]   passValue;
    logic [P-1:0]   prbsNext;
    logic [P-1:0]   payload_q;
    logic [P-1:0]   payload_d;

    assign modeIn     = mode_e'(lb.in[1:0]);
    assign data       = lb.in[IN_W-1:2];
    assign modeChange = (modeIn != mode_q);

    // Prefix XOR over d; PASS keeps only the top P taps of the chain.
    always_comb begin
        chain    = '0;
        chain[0] = 1'b1;
        for (int i = 0; i < D; i++) begin
            chain[i+1] = chain[i] ^ data[i];
        end
    end

    assign passValue = chain[D:D-P+1];

    loopback_prbs #(.P(P)) uPrbs (
        .state_i (payload_q),
        .next_o  (prbsNext)
    );

    always_comb begin
        payload_d = payload_q;
        unique case (modeIn)
            MODE_PASS:  payload_d = passValue;
            MODE_COUNT: payload_d = modeChange ? {P{SEED_FILL_COUNT}} : payload_q + P'(1);
            MODE_LFSR: begin
                if (modeChange || payload_q == '0) begin
                    payload_d = {P{SEED_FILL_PRBS}};
                end else begin
                    payload_d = prbsNext;
                end
            end
            MODE_MISR:  payload_d = modeChange ? {P{SEED_FILL_PRBS}} : prbsNext ^ data[P-1:0];
        endcase
    end

    // Reset wins over a same-cycle mode change and clears the mode history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            payload_q <= '0;
            mode_q    <= MODE_PASS;
        end else begin
            payload_q <= payload_d;
            mode_q    <= modeIn;
        end
    end

`ifdef LOOPBACK_CLK_PASS_EN
    assign lb.out = {payload_q, clk};
`else
    logic toggle_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= ~toggle_q;
        end
    end

    assign lb.out = {payload_q, toggle_q};
`endif

endmodule

// File: tb/tb_loopback_gen.sv
// Randomised and directed bench for loopback_gen against a behavioural model of the mode rules.
module tb_loopback_gen;

    localparam int IN_W  = 9;
    localparam int OUT_W = 8;
    localparam int D     = IN_W - 2;
    localparam int P     = OUT_W - 1;
    localparam int PMASK = (1 << P) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    loopback_gen_if #(.IN_W(IN_W), .OUT_W(OUT_W)) lbIf ();

    loopback_gen #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lb    (lbIf)
    );

    always #5 clk = ~clk;

    int errorCount = 0;
    int checkCount = 0;

    int modelP    = 0;
    int modelMode = 0;
    int modelTog  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // PASS bit k is 1 xor the parity of d[0 .. D-P+k].
    function automatic int refPass(input int d);
        int res = 0;
        for (int k = 0; k < P; k++) begin
            int mask = (1 << (D - P + k + 1)) - 1;
            int par  = $countones(d & mask) % 2;
            res |= ((1 ^ par) << k);
        end
        return res;
    endfunction

    function automatic int refStep(input int s);
        return (s >> 1) ^ (((s & 1) != 0) ? 'h60 : 0);
    endfunction

    task automatic modelUpdate(input int inVal, input logic rstVal);
        int m;
        int d;
        bit change;
        if (!rstVal) begin
            modelP = 0; modelMode = 0; modelTog = 0;
        end else begin
            m = inVal & 3;
            d = (inVal >> 2) & ((1 << D) - 1);
            change = (m != modelMode);
            case (m)
                0: modelP = refPass(d);
                1: modelP = change ? 0 : (modelP + 1) % (1 << P);
                2: modelP = (change || modelP == 0) ? PMASK : refStep(modelP);
                default: modelP = change ? PMASK : (refStep(modelP) ^ (d & PMASK));
            endcase
            modelMode = m;
            modelTog ^= 1;
        end
    endtask

    task automatic applyStimulus(input string tag, input int inVal, input logic rstVal);
        @(negedge clk);
        #1;
`ifdef LOOPBACK_CLK_PASS_EN
        checkOutput({tag, "_clkLow"}, 32'(lbIf.out[0]), 32'd0);
`else
        checkOutput({tag, "_clkHold"}, 32'(lbIf.out[0]), 32'(modelTog));
`endif
        lbIf.in = IN_W'(inVal);
        rst_n   = rstVal;
        modelUpdate(inVal, rstVal);
        @(posedge clk);
        #1;
        checkOutput({tag, "_payload"}, 32'(lbIf.out[OUT_W-1:1]), 32'(modelP));
`ifdef LOOPBACK_CLK_PASS_EN
        checkOutput({tag, "_clkHigh"}, 32'(lbIf.out[0]), 32'd1);
`else
        checkOutput({tag, "_clkBit"}, 32'(lbIf.out[0]), 32'(modelTog));
`endif
    endtask

    function automatic int mk(input int mode, input int d);
        return ((d & ((1 << D) - 1)) << 2) | (mode & 3);
    endfunction

    function automatic int payloadNow();
        return int'(lbIf.out[OUT_W-1:1]);
    endfunction

    initial begin
        int firstReturn;
        int zeroSeen;
        lbIf.in = 9'h1FF;
        rst_n   = 1'b0;

        // Reset with all inputs high, then release into PASS with d = 0.
        applyStimulus("rst0", 'h1FF, 1'b0);
        applyStimulus("rst1", 'h1FF, 1'b0);
        checkOutput("rst_payloadZero", 32'(payloadNow()), 32'h00);
        applyStimulus("rel", 0, 1'b1);
        checkOutput("rel_pass7F", 32'(payloadNow()), 32'h7F);

        applyStimulus("pass01", mk(0, 'h01), 1'b1);
        checkOutput("pass_d01", 32'(payloadNow()), 32'h00);
        applyStimulus("pass02", mk(0, 'h02), 1'b1);
        checkOutput("pass_d02", 32'(payloadNow()), 32'h01);
        applyStimulus("pass00", mk(0, 'h00), 1'b1);
        checkOutput("pass_d00", 32'(payloadNow()), 32'h7F);

        // COUNT held for 129 cycles: seed 0, reaches 0x7F at 127, wraps at 128.
        for (int i = 0; i <= 128; i++) begin
            applyStimulus("count", mk(1, $urandom), 1'b1);
            if (i == 0)   checkOutput("count_seed", 32'(payloadNow()), 32'h00);
            if (i == 1)   checkOutput("count_one", 32'(payloadNow()), 32'h01);
            if (i == 127) checkOutput("count_top", 32'(payloadNow()), 32'h7F);
            if (i == 128) checkOutput("count_wrap", 32'(payloadNow()), 32'h00);
        end

        // LFSR period must be exactly 127 with no zero state.
        firstReturn = -1;
        zeroSeen = 0;
        for (int i = 0; i <= 127; i++) begin
            applyStimulus("lfsr", mk(2, $urandom), 1'b1);
            if (i == 0) checkOutput("lfsr_seed", 32'(payloadNow()), 32'h7F);
            if (i == 1) checkOutput("lfsr_s1", 32'(payloadNow()), 32'h5F);
            if (i == 2) checkOutput("lfsr_s2", 32'(payloadNow()), 32'h4F);
            if (payloadNow() == 0) zeroSeen++;
            if (i > 0 && firstReturn < 0 && payloadNow() == 'h7F) firstReturn = i;
        end
        checkOutput("lfsr_period", 32'(firstReturn), 32'd127);
        checkOutput("lfsr_noZero", 32'(zeroSeen), 32'd0);

        applyStimulus("misrA0", mk(3, 'h01), 1'b1);
        checkOutput("misr_seedA", 32'(payloadNow()), 32'h7F);
        applyStimulus("misrA1", mk(3, 'h01), 1'b1);
        checkOutput("misr_stepA", 32'(payloadNow()), 32'h5E);
        applyStimulus("toLfsr", mk(2, 'h00), 1'b1);
        checkOutput("misr_toLfsrSeed", 32'(payloadNow()), 32'h7F);
        applyStimulus("misrB0", mk(3, 'h00), 1'b1);
        checkOutput("misr_seedB", 32'(payloadNow()), 32'h7F);
        applyStimulus("misrB1", mk(3, 'h00), 1'b1);
        checkOutput("misr_stepB", 32'(payloadNow()), 32'h5F);

        // Reset mid-COUNT with a mode change pending, then release into COUNT.
        for (int i = 0; i < 5; i++) applyStimulus("cnt2", mk(1, 0), 1'b1);
        applyStimulus("rstMid", mk(3, 'h55), 1'b0);
        checkOutput("rstMid_zero", 32'(payloadNow()), 32'h00);
        applyStimulus("relCnt0", mk(1, 0), 1'b1);
        checkOutput("relCnt_seed", 32'(payloadNow()), 32'h00);
        applyStimulus("relCnt1", mk(1, 0), 1'b1);
        checkOutput("relCnt_one", 32'(payloadNow()), 32'h01);

        // Random traffic: modes tend to persist for a while, occasional reset.
        for (int i = 0; i < 600; i++) begin
            int md = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : modelMode;
            logic r = ($urandom_range(0, 60) != 0);
            applyStimulus("rand", mk(md, $urandom), r);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
